// File: rtl/ahb_arb_pkg.sv
// Shared types and defaults for the AHB weighted round-robin arbiter.
package ahb_arb_pkg;

    localparam int NUM_MASTERS            = 16;
    localparam int IDX_W                  = 4;
    localparam int QUOTA_DEFAULT          = 4;
    localparam int DEFAULT_MASTER_DEFAULT = 0;

    typedef logic [NUM_MASTERS-1:0] master_vec_t;
    typedef logic [IDX_W-1:0]       master_idx_t;
    typedef logic [3:0]             beat_cnt_t;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        BUSY   = 2'b01,
        NONSEQ = 2'b10,
        SEQ    = 2'b11
    } htrans_t;

    typedef enum logic [1:0] {
        OKAY  = 2'b00,
        ERROR = 2'b01,
        RETRY = 2'b10,
        SPLIT = 2'b11
    } hresp_t;

endpackage

// File: rtl/ahb_wrr_arbiter_if.sv
// Arbitration signal bundle. The slave modport is the arbiter's view
// (requests in, grants out); the master modport is the requesting side.
interface ahb_wrr_arbiter_if;
    import ahb_arb_pkg::*;

    master_vec_t HBUSREQx;
    master_vec_t HLOCKx;
    master_vec_t HSPLIT;
    logic        HREADY;
    htrans_t     HTRANS;
    hresp_t      HRESP;
    master_vec_t HGRANTx;
    master_idx_t HMASTER;
    logic        HMASTLOCK;

    modport slave (
        input  HBUSREQx, HLOCKx, HSPLIT, HREADY, HTRANS, HRESP,
        output HGRANTx, HMASTER, HMASTLOCK
    );

    modport master (
        output HBUSREQx, HLOCKx, HSPLIT, HREADY, HTRANS, HRESP,
        input  HGRANTx, HMASTER, HMASTLOCK
    );

endinterface

// File: rtl/rr_priority_picker.sv
// Rotating-priority search: first set bit of eligible at or after start,
// wrapping modulo NUM_MASTERS.
module rr_priority_picker
    import ahb_arb_pkg::*;
(
    input  master_vec_t eligible,
    input  master_idx_t start,
    output logic        valid,
    output master_idx_t index
);

    // Scan from start upward; the first hit wins.
    always_comb begin
        // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
        valid = 1'b0;
        index = start;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (!valid && eligible[start + master_idx_t'(i)]) begin
                valid = 1'b1;
                index = start + master_idx_t'(i);
            end
        end
    end

endmodule

// File: rtl/ahb_wrr_arbiter.sv
// AHB bus arbiter: round-robin between requesters with a per-tenure beat
// quota, locked-transfer hold, and SPLIT masking.
module ahb_wrr_arbiter
    import ahb_arb_pkg::*;
#(
    parameter int QUOTA          = QUOTA_DEFAULT,
    parameter int DEFAULT_MASTER = DEFAULT_MASTER_DEFAULT
) (
    input logic              HCLK,
    input logic              HRESETn,
    ahb_wrr_arbiter_if.slave bus
);

    localparam master_idx_t DEF_IDX   = master_idx_t'(DEFAULT_MASTER);
    localparam beat_cnt_t   QUOTA_C   = beat_cnt_t'(QUOTA);
    localparam master_vec_t DEF_GRANT = master_vec_t'(1) << DEF_IDX;

    master_vec_t grant_vec;
    master_idx_t grant_idx;
    master_idx_t owner_idx;
    logic        owner_lock;
    beat_cnt_t   beat_cnt;
    beat_cnt_t   beat_cnt_next;
    master_vec_t split_mask;
    master_vec_t split_mask_next;

    master_vec_t eligible;
    master_idx_t search_start;
    logic        pick_valid;
    master_idx_t pick_idx;
    master_idx_t winner;
    logic        locked_hold;
    logic        quota_hit;
    logic        rearb;
    logic        beat_active;

    assign eligible     = bus.HBUSREQx & ~split_mask;
    assign search_start = owner_idx + master_idx_t'(1);

    rr_priority_picker u_picker (
        .eligible (eligible),
        .start    (search_start),
        .valid    (pick_valid),
        .index    (pick_idx)
    );

    // Decide whether the current grant is released and who takes it next.
    always_comb begin
        beat_active = (bus.HTRANS == NONSEQ) || (bus.HTRANS == SEQ);
        winner      = pick_valid ? pick_idx : DEF_IDX;
        locked_hold = bus.HLOCKx[grant_idx] && bus.HBUSREQx[grant_idx];
        // The count belongs to the owner; it only applies once grant and ownership agree.
        quota_hit   = (grant_idx == owner_idx) && (beat_cnt == QUOTA_C);
        rearb       = !locked_hold &&
                      (!bus.HBUSREQx[grant_idx] || split_mask[grant_idx] || quota_hit);
    end

    // Next beat count and split mask; a SPLIT set beats a same-edge release.
    always_comb begin
        beat_cnt_next = beat_cnt;
        if (bus.HREADY) begin
            if ((grant_idx != owner_idx) || (rearb && (winner == grant_idx))) begin
                beat_cnt_next = '0;
            end else if (beat_active && (beat_cnt < QUOTA_C)) begin
                beat_cnt_next = beat_cnt + beat_cnt_t'(1);
            end
        end
        split_mask_next = split_mask & ~bus.HSPLIT;
        if ((bus.HRESP == SPLIT) && !bus.HREADY) begin
            split_mask_next[owner_idx] = 1'b1;
        end
    end

    // Single register stage for grant, ownership, lock, beat count and split mask.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            grant_vec  <= DEF_GRANT;
            grant_idx  <= DEF_IDX;
            owner_idx  <= DEF_IDX;
            owner_lock <= 1'b0;
            beat_cnt   <= '0;
            split_mask <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            beat_cnt   <= beat_cnt_next;
            split_mask <= split_mask_next;
            if (bus.HREADY) begin
                owner_idx  <= grant_idx;
                owner_lock <= bus.HLOCKx[grant_idx];
                if (rearb) begin
                    grant_idx <= winner;
                    grant_vec <= master_vec_t'(1) << winner;
                end
            end
        end
    end

    assign bus.HGRANTx   = grant_vec;
    assign bus.HMASTER   = owner_idx;
    assign bus.HMASTLOCK = owner_lock;

endmodule

// File: tb/tb_ahb_wrr_arbiter.sv
// Directed bench for ahb_wrr_arbiter (QUOTA=4, DEFAULT_MASTER=0).
// Stimulus pushes the hand-computed post-edge outputs into a queue;
// the monitor pops and compares one entry per clock edge.
module tb_ahb_wrr_arbiter;
    import ahb_arb_pkg::*;

    typedef struct {
        logic [15:0] grant;
        logic [3:0]  master;
        logic        lock;
        int          id;
    } exp_t;

    logic HCLK;
    logic HRESETn;
    ahb_wrr_arbiter_if bus ();

    ahb_wrr_arbiter #(
        .QUOTA          (4),
        .DEFAULT_MASTER (0)
    ) dut (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .bus     (bus)
    );

    exp_t exp_q[$];
    int   total     = 0;
    int   bad       = 0;
    int   vec_no    = 0;
    bit   stim_done = 0;

    initial begin
        HCLK = 1'b0;
        forever #5 HCLK = ~HCLK;
    end

    function automatic logic [3:0] oh_idx(input logic [15:0] v);
        logic [3:0] r;
        r = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (v[i]) r = 4'(i);
        end
        return r;
    endfunction

    task automatic check(input string name, input int id, input logic [15:0] act,
                         input logic [15:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s vec=%0d got=%h want=%h", name, id, act, want);
        end
    endtask

    // Drive one cycle of inputs at a falling edge and queue the outputs
    // expected after the following rising edge.
    task automatic step(input logic [15:0] req, input logic [15:0] lk, input logic [15:0] spl,
                        input logic rdy, input htrans_t tr, input hresp_t rs,
                        input logic [15:0] eg, input logic [3:0] em, input logic el);
        exp_t e;
        bus.HBUSREQx = req;
        bus.HLOCKx   = lk;
        bus.HSPLIT   = spl;
        bus.HREADY   = rdy;
        bus.HTRANS   = tr;
        bus.HRESP    = rs;
        e.grant  = eg;
        e.master = em;
        e.lock   = el;
        e.id     = vec_no;
        exp_q.push_back(e);
        vec_no++;
        @(negedge HCLK);
    endtask

    // Monitor: pops one expectation per edge, plus the every-cycle properties.
    initial begin : monitor
        exp_t e;
        int   cycles;
        logic last_lock;
        cycles    = 0;
        last_lock = 1'b0;
        while (!(stim_done && exp_q.size() == 0)) begin
            @(posedge HCLK);
            if (!HRESETn) last_lock = 1'b0;
            else if (bus.HREADY) last_lock = bus.HLOCKx[oh_idx(bus.HGRANTx)];
            #1;
            cycles++;
            if (cycles > 5000) begin
                total++;
                bad++;
                $display("FAIL timeout cycles=%0d pending=%0d", cycles, exp_q.size());
                break;
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("grant",  e.id, bus.HGRANTx, e.grant);
                check("master", e.id, 16'(bus.HMASTER), 16'(e.master));
                check("lock",   e.id, 16'(bus.HMASTLOCK), 16'(e.lock));
            end
            if (HRESETn) begin
                check("onehot", -1, 16'($onehot(bus.HGRANTx)), 16'd1);
                check("lock_implies", -1, 16'(bus.HMASTLOCK & ~last_lock), 16'd0);
            end
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : stimulus
        logic [15:0] g;
        logic [3:0]  m;
        int          r;
        bit          two;
        HRESETn      = 1'b0;
        bus.HBUSREQx = '0;
        bus.HLOCKx   = '0;
        bus.HSPLIT   = '0;
        bus.HREADY   = 1'b1;
        bus.HTRANS   = IDLE;
        bus.HRESP    = OKAY;
        @(negedge HCLK);

        // Held in reset: default grant, owner 0, no lock.
        repeat (2) step(16'h0, 16'h0, 16'h0, 1'b1, IDLE, OKAY, 16'h0001, 4'd0, 1'b0);
        HRESETn = 1'b1;

        // Idle bus parks on the default master.
        repeat (10) step(16'h0, 16'h0, 16'h0, 1'b1, IDLE, OKAY, 16'h0001, 4'd0, 1'b0);

        // Masters 1 and 2 alternate: each tenure is 4 counted beats plus the
        // grant-change cycle and the ownership-change cycle (6 edges per grant).
        for (int n = 1; n <= 24; n++) begin
            if (n == 1) begin
                g = 16'h0002; m = 4'd0;
            end else if (n < 7) begin
                g = 16'h0002; m = 4'd1;
            end else begin
                r   = (n - 7) % 6;
                two = (((n - 7) / 6) % 2) == 0;
                g   = two ? 16'h0004 : 16'h0002;
                m   = (r == 0) ? (two ? 4'd1 : 4'd2) : (two ? 4'd2 : 4'd1);
            end
            step(16'h0006, 16'h0, 16'h0, 1'b1, (n % 4 == 1) ? NONSEQ : SEQ, OKAY, g, m, 1'b0);
        end

        // Locked master 3 keeps the bus past its quota while master 5 waits.
        step(16'h0028, 16'h0008, 16'h0, 1'b1, SEQ, OKAY, 16'h0008, 4'd2, 1'b0);
        repeat (10) step(16'h0028, 16'h0008, 16'h0, 1'b1, SEQ, OKAY, 16'h0008, 4'd3, 1'b1);
        step(16'h0028, 16'h0000, 16'h0, 1'b1, SEQ, OKAY, 16'h0020, 4'd3, 1'b0);
        step(16'h0028, 16'h0000, 16'h0, 1'b1, SEQ, OKAY, 16'h0020, 4'd5, 1'b0);

        // Handover requested while HREADY is low: nothing moves until HREADY=1.
        repeat (5) step(16'h0080, 16'h0, 16'h0, 1'b0, SEQ, OKAY, 16'h0020, 4'd5, 1'b0);
        step(16'h0080, 16'h0, 16'h0, 1'b1, SEQ, OKAY, 16'h0080, 4'd5, 1'b0);
        step(16'h0080, 16'h0, 16'h0, 1'b1, SEQ, OKAY, 16'h0080, 4'd7, 1'b0);

        // Master 2 is split, master 4 takes over, HSPLIT[2] makes 2 eligible again.
        step(16'h0014, 16'h0, 16'h0, 1'b1, SEQ,    OKAY,  16'h0004, 4'd7, 1'b0);
        step(16'h0014, 16'h0, 16'h0, 1'b1, SEQ,    OKAY,  16'h0004, 4'd2, 1'b0);
        step(16'h0014, 16'h0, 16'h0, 1'b1, SEQ,    OKAY,  16'h0004, 4'd2, 1'b0);
        step(16'h0014, 16'h0, 16'h0, 1'b0, IDLE,   SPLIT, 16'h0004, 4'd2, 1'b0);
        step(16'h0014, 16'h0, 16'h0, 1'b1, IDLE,   SPLIT, 16'h0010, 4'd2, 1'b0);
        step(16'h0014, 16'h0, 16'h0, 1'b1, NONSEQ, OKAY,  16'h0010, 4'd4, 1'b0);
        step(16'h0014, 16'h0, 16'h4, 1'b1, SEQ,    OKAY,  16'h0010, 4'd4, 1'b0);
        step(16'h0004, 16'h0, 16'h0, 1'b1, SEQ,    OKAY,  16'h0004, 4'd4, 1'b0);
        step(16'h0004, 16'h0, 16'h0, 1'b1, NONSEQ, OKAY,  16'h0004, 4'd2, 1'b0);

        // Every requester masked (including the default master): default granted.
        step(16'h0004, 16'h0, 16'h0, 1'b0, IDLE, SPLIT, 16'h0004, 4'd2, 1'b0);
        step(16'h0004, 16'h0, 16'h0, 1'b1, IDLE, SPLIT, 16'h0001, 4'd2, 1'b0);
        step(16'h0004, 16'h0, 16'h0, 1'b1, IDLE, OKAY,  16'h0001, 4'd0, 1'b0);
        step(16'h0005, 16'h0, 16'h0, 1'b1, IDLE, OKAY,  16'h0001, 4'd0, 1'b0);
        step(16'h0005, 16'h0, 16'h0, 1'b0, IDLE, SPLIT, 16'h0001, 4'd0, 1'b0);
        step(16'h0005, 16'h0, 16'h0, 1'b1, IDLE, SPLIT, 16'h0001, 4'd0, 1'b0);
        step(16'h0005, 16'h0, 16'h5, 1'b1, IDLE, OKAY,  16'h0001, 4'd0, 1'b0);
        step(16'h0004, 16'h0, 16'h0, 1'b1, IDLE, OKAY,  16'h0004, 4'd0, 1'b0);
        step(16'h0004, 16'h0, 16'h0, 1'b1, IDLE, OKAY,  16'h0004, 4'd2, 1'b0);

        // SPLIT and HSPLIT on the same bit and edge: the mask stays set.
        step(16'h0004, 16'h0, 16'h4, 1'b0, IDLE, SPLIT, 16'h0004, 4'd2, 1'b0);
        step(16'h0004, 16'h0, 16'h0, 1'b1, IDLE, OKAY,  16'h0001, 4'd2, 1'b0);
        step(16'h0004, 16'h0, 16'h4, 1'b1, IDLE, OKAY,  16'h0001, 4'd0, 1'b0);
        step(16'h0004, 16'h0, 16'h0, 1'b1, IDLE, OKAY,  16'h0004, 4'd0, 1'b0);
        step(16'h0004, 16'h0, 16'h0, 1'b1, IDLE, OKAY,  16'h0004, 4'd2, 1'b0);

        // RETRY and ERROR leave mask and grant alone.
        step(16'h0004, 16'h0, 16'h0, 1'b0, IDLE, RETRY, 16'h0004, 4'd2, 1'b0);
        step(16'h0004, 16'h0, 16'h0, 1'b1, IDLE, RETRY, 16'h0004, 4'd2, 1'b0);
        step(16'h0004, 16'h0, 16'h0, 1'b0, IDLE, ERROR, 16'h0004, 4'd2, 1'b0);
        step(16'h0004, 16'h0, 16'h0, 1'b1, IDLE, ERROR, 16'h0004, 4'd2, 1'b0);

        // Lone requester keeps the bus across several quota expiries.
        repeat (12) step(16'h0004, 16'h0, 16'h0, 1'b1, SEQ, OKAY, 16'h0004, 4'd2, 1'b0);

        // Reset mid-burst, then arbitration restarts from DEFAULT_MASTER+1.
        #2;
        HRESETn = 1'b0;
        step(16'h0006, 16'h0, 16'h0, 1'b1, NONSEQ, OKAY, 16'h0001, 4'd0, 1'b0);
        HRESETn = 1'b1;
        step(16'h0006, 16'h0, 16'h0, 1'b1, NONSEQ, OKAY, 16'h0002, 4'd0, 1'b0);
        step(16'h0006, 16'h0, 16'h0, 1'b1, SEQ,    OKAY, 16'h0002, 4'd1, 1'b0);

        stim_done = 1'b1;
    end

endmodule

// File: doc/ahb_wrr_arbiter.md
AHB_WRR_ARBITER -- requirements
Module: ahb_wrr_arbiter

Interface
REQ-001 Parameter QUOTA, 4, max data beats a master may own per tenure before re-arbitration (range 1..15).
REQ-002 Parameter DEFAULT_MASTER, 0, master index granted when no eligible request exists.
REQ-003 HCLK  input  1  sole clock; all state on rising edge.
REQ-004 HRESETn  input  1  reset, asynchronous, active-low.
REQ-005 HBUSREQx  input  16  per-master bus request.
REQ-006 HLOCKx  input  16  per-master locked-transfer request.
REQ-007 HSPLIT  input  16  per-master split release from slaves.
REQ-008 HREADY  input  1  transfer-complete / handover qualifier.
REQ-009 HTRANS  input  2  current address-phase transfer type (IDLE=00, BUSY=01, NONSEQ=10, SEQ=11).
REQ-010 HRESP  input  2  slave response (OKAY=00, ERROR=01, RETRY=10, SPLIT=11).
REQ-011 HGRANTx  output  16  registered one-hot grant.
REQ-012 HMASTER  output  4  index of master owning the address phase.
REQ-013 HMASTLOCK  output  1  current transfer is locked.

Function
REQ-014 HGRANTx SHALL be exactly one-hot in every cycle after reset.
REQ-015 Eligible set = HBUSREQx & ~split_mask; the next owner SHALL be the first eligible index searched from (HMASTER+1) mod 16 upward, wrapping; if none eligible, DEFAULT_MASTER.
REQ-016 Re-arbitration SHALL be requested when the granted master deasserts HBUSREQx, its beat count equals QUOTA, or it becomes split-masked.
REQ-017 While HLOCKx[granted] and HBUSREQx[granted] are both 1, re-arbitration SHALL be suppressed regardless of beat count.
REQ-018 A new HGRANTx value SHALL load only on an edge where HREADY=1; with HREADY=0 grant holds.
REQ-019 HMASTER SHALL load the index of the previous HGRANTx on every edge with HREADY=1 (one-cycle grant-to-ownership latency).
REQ-020 HMASTLOCK SHALL load HLOCKx[granted index] on the same edges as HMASTER.
REQ-021 Beat counter (4 bits) SHALL increment on edges with HREADY=1 and HTRANS in {NONSEQ, SEQ}, saturate at QUOTA, and clear when HMASTER changes.
REQ-022 split_mask[HMASTER] SHALL set on an edge with HRESP=SPLIT and HREADY=0.
REQ-023 split_mask[i] SHALL clear on an edge where HSPLIT[i]=1; if set and clear coincide for the same bit, set wins.
REQ-024 When all requesters are split-masked, DEFAULT_MASTER SHALL be granted even if itself masked.
REQ-025 A single requester SHALL be re-granted to itself after QUOTA beats (counter clears, no idle gap).
REQ-026 HRESP=RETRY or ERROR SHALL NOT alter split_mask or grant.

Reset
REQ-027 On HRESETn=0, asynchronously: HGRANTx=1<<DEFAULT_MASTER, HMASTER=DEFAULT_MASTER, HMASTLOCK=0, beat counter=0, split_mask=0.
REQ-028 Reset assertion mid-burst SHALL abandon the tenure; first post-reset arbitration starts from DEFAULT_MASTER+1.

Structure
REQ-029 Package ahb_arb_pkg SHALL hold NUM_MASTERS=16, htrans_t and hresp_t enums, and default parameter constants.
REQ-030 Rotating priority search SHALL be a combinational sub-module rr_priority_picker (inputs: 16-bit eligible, 4-bit start; outputs: valid, 4-bit index).
REQ-031 RTL SHALL contain one grant/ownership register stage only; no additional pipelining.

Verification
REQ-032 Reset, HBUSREQx=0 -> HGRANTx=16'h0001, HMASTER=0, HMASTLOCK=0 for 10 cycles.
REQ-033 HBUSREQx=16'h0006, HREADY=1, continuous NONSEQ/SEQ -> grant alternates 1,2,1,2 every 4 beats; HMASTER follows one cycle later.
REQ-034 Master 3 requests with HLOCKx[3]=1 for 10 beats, master 5 requesting -> grant stays 16'h0008, HMASTLOCK=1 for all 10; then grant 16'h0020.
REQ-035 Master 2 owner, HRESP=SPLIT with HREADY=0 -> split_mask[2]=1, grant moves to next eligible; HSPLIT[2]=1 pulse -> master 2 eligible next round.
REQ-036 HREADY held 0 for 5 cycles during a handover request -> HGRANTx and HMASTER unchanged until HREADY=1.
REQ-037 Every cycle: assertion $onehot(HGRANTx) and HMASTLOCK implies HLOCKx[HMASTER] sampled at last handover.
